// File: rtl/block_coord_scan_pkg.sv
// Shared definitions for the block coordinate scanner: state encoding,
// default coordinate width and signed saturation limits at that width.
package coord_pkg;

  localparam int COORD_W_DEFAULT = 8;

  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_RUN  = 2'd1;
  localparam logic [1:0] STATE_FIN  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = STATE_IDLE,
    RUN  = STATE_RUN,
    FIN  = STATE_FIN
  } scan_state_t;

  localparam logic signed [COORD_W_DEFAULT-1:0] SAT_MAX_DEFAULT = {1'b0, {(COORD_W_DEFAULT-1){1'b1}}};
  localparam logic signed [COORD_W_DEFAULT-1:0] SAT_MIN_DEFAULT = {1'b1, {(COORD_W_DEFAULT-1){1'b0}}};

endpackage

// File: rtl/block_coord_scan_if.sv
// Handshake bundle between the block controller / scanner and the
// reference-pixel fetch stage. OFFSET_X/OFFSET_Y exist only when
// COORD_OFFSET_EN is defined.
interface block_coord_scan_if #(
  parameter int COORD_W = 8
);

  logic                      START;
  logic signed [COORD_W-1:0] ORIGIN_X;
  logic signed [COORD_W-1:0] ORIGIN_Y;
  logic                      READY;
  logic signed [COORD_W-1:0] COORD_X;
  logic signed [COORD_W-1:0] COORD_Y;
  logic                      VALID;
  logic                      LAST;
  logic                      BUSY;
  logic                      DONE;
`ifdef COORD_OFFSET_EN
  logic signed [COORD_W-1:0] OFFSET_X;
  logic signed [COORD_W-1:0] OFFSET_Y;
`endif

  // Scanner side: produces coordinates.
  modport master (
`ifdef COORD_OFFSET_EN
    input  OFFSET_X, OFFSET_Y,
`endif
    input  START, ORIGIN_X, ORIGIN_Y, READY,
    output COORD_X, COORD_Y, VALID, LAST, BUSY, DONE
  );

  // Controller / consumer side.
  modport slave (
`ifdef COORD_OFFSET_EN
    output OFFSET_X, OFFSET_Y,
`endif
    output START, ORIGIN_X, ORIGIN_Y, READY,
    input  COORD_X, COORD_Y, VALID, LAST, BUSY, DONE
  );

endinterface

// File: rtl/block_coord_scan_sat_add.sv
// Signed two's complement adder that clamps to the representable range
// instead of wrapping. Used to apply the motion-vector offset.
module coord_sat_add
  import coord_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEFAULT
) (
  input  logic signed [COORD_W-1:0] addend_a,
  input  logic signed [COORD_W-1:0] addend_b,
  output logic signed [COORD_W-1:0] sum
);

  localparam logic signed [COORD_W-1:0] MAX_V = {1'b0, {(COORD_W-1){1'b1}}};
  localparam logic signed [COORD_W-1:0] MIN_V = {1'b1, {(COORD_W-1){1'b0}}};

  logic [COORD_W:0] wide_sum;

  // One guard bit detects overflow; the guard bit's sign picks the clamp direction.
  always_comb begin
    wide_sum = {addend_a[COORD_W-1], addend_a} + {addend_b[COORD_W-1], addend_b};
    if (wide_sum[COORD_W] != wide_sum[COORD_W-1]) begin
      sum = wide_sum[COORD_W] ? MIN_V : MAX_V;
    end else begin
      sum = wide_sum[COORD_W-1:0];
    end
  end

endmodule

// File: rtl/block_coord_scan.sv
// Raster-order block origin generator. After START it walks NUM_COLS x
// NUM_ROWS blocks and presents each block's signed upper-left coordinate
// on a VALID/READY handshake, then pulses DONE for one cycle.
// Optional feature macro: COORD_OFFSET_EN (adds saturating offset).
module block_coord_scan
  import coord_pkg::*;
#(
  parameter int COORD_W  = COORD_W_DEFAULT,
  parameter int BLK_W    = 8,
  parameter int BLK_H    = 8,
  parameter int NUM_COLS = 4,
  parameter int NUM_ROWS = 4
) (
  input logic             CLK,
  input logic             RST_SYNC,
  block_coord_scan_if.master bus
);

  localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);

  localparam logic signed [COORD_W-1:0] STEP_X = COORD_W'(BLK_W);
  localparam logic signed [COORD_W-1:0] STEP_Y = COORD_W'(BLK_H);

  scan_state_t               state;
  logic [COL_W-1:0]          col;
  logic [ROW_W-1:0]          row;
  logic signed [COORD_W-1:0] origin_x;
  logic signed [COORD_W-1:0] scan_x;
  logic signed [COORD_W-1:0] scan_y;
  logic                      valid_q;
  logic                      last_q;
  logic                      busy_q;
  logic                      done_q;

  logic                      transfer;
  logic                      load;
  logic [COL_W-1:0]          next_col;
  logic [ROW_W-1:0]          next_row;
  logic signed [COORD_W-1:0] next_x;
  logic signed [COORD_W-1:0] next_y;
  logic                      next_last;

  assign transfer = valid_q & bus.READY;

  // Work out the coordinate to load next: the region origin on START, or
  // the raster successor of the current block when it is accepted and is
  // not the final one.
  always_comb begin
    load     = 1'b0;
    next_col = col;
    next_row = row;
    next_x   = scan_x;
    next_y   = scan_y;
    if (state == IDLE && bus.START) begin
      load     = 1'b1;
      next_col = '0;
      next_row = '0;
      next_x   = bus.ORIGIN_X;
      next_y   = bus.ORIGIN_Y;
    end else if (state == RUN && transfer && !last_q) begin
      load = 1'b1;
      if (col != COL_LAST) begin
        next_col = col + COL_W'(1);
        next_x   = scan_x + STEP_X;
      end else begin
        next_col = '0;
        next_row = row + ROW_W'(1);
        next_x   = origin_x;
        next_y   = scan_y + STEP_Y;
      end
    end
    next_last = (next_col == COL_LAST) && (next_row == ROW_LAST);
  end

`ifdef COORD_OFFSET_EN
  logic signed [COORD_W-1:0] offset_x_sum;
  logic signed [COORD_W-1:0] offset_y_sum;
  logic signed [COORD_W-1:0] out_x;
  logic signed [COORD_W-1:0] out_y;

  coord_sat_add #(.COORD_W(COORD_W)) u_sat_x (
    .addend_a (next_x),
    .addend_b (bus.OFFSET_X),
    .sum      (offset_x_sum)
  );

  coord_sat_add #(.COORD_W(COORD_W)) u_sat_y (
    .addend_a (next_y),
    .addend_b (bus.OFFSET_Y),
    .sum      (offset_y_sum)
  );

  assign bus.COORD_X = out_x;
  assign bus.COORD_Y = out_y;
`else
  assign bus.COORD_X = scan_x;
  assign bus.COORD_Y = scan_y;
`endif

  assign bus.VALID = valid_q;
  assign bus.LAST  = last_q;
  assign bus.BUSY  = busy_q;
  assign bus.DONE  = done_q;

  // Scan FSM plus coordinate/counter registers; reset overrides everything.
  always_ff @(posedge CLK) begin
    if (RST_SYNC) begin
      state    <= IDLE;
      col      <= '0;
      row      <= '0;
      origin_x <= '0;
      scan_x   <= '0;
      scan_y   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef COORD_OFFSET_EN
      out_x    <= '0;
      out_y    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.START) begin
            state    <= RUN;
            origin_x <= bus.ORIGIN_X;
            valid_q  <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        RUN: begin
          if (transfer && last_q) begin
            state   <= FIN;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        FIN: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase

      if (load) begin
        col    <= next_col;
        row    <= next_row;
        scan_x <= next_x;
        scan_y <= next_y;
        last_q <= next_last;
`ifdef COORD_OFFSET_EN
        out_x  <= offset_x_sum;
        out_y  <= offset_y_sum;
`endif
      end
    end
  end

endmodule

// File: tb/tb_block_coord_scan.sv
// Self-checking bench for block_coord_scan. Reference coordinates are
// computed from block index arithmetic (k mod cols, k div cols) with
// explicit wrap/saturation, independent of the scanner's counters.
module tb_block_coord_scan;

  localparam int CW   = 8;
  localparam int BW   = 8;
  localparam int BH   = 4;
  localparam int NC   = 3;
  localparam int NR   = 2;
  localparam int NBLK = NC * NR;
  localparam int MAXI = (1 << (CW - 1)) - 1;
  localparam int MINI = -(1 << (CW - 1));

  logic CLK = 1'b0;
  logic RST_SYNC;

  int checks   = 0;
  int failures = 0;

`ifdef COORD_OFFSET_EN
  int cur_off_x = 0;
  int cur_off_y = 0;
`endif

  always #5 CLK = ~CLK;

  block_coord_scan_if #(.COORD_W(CW)) bus ();

  block_coord_scan #(
    .COORD_W  (CW),
    .BLK_W    (BW),
    .BLK_H    (BH),
    .NUM_COLS (NC),
    .NUM_ROWS (NR)
  ) dut (
    .CLK      (CLK),
    .RST_SYNC (RST_SYNC),
    .bus      (bus)
  );

  // Hard stop in case something stalls the whole run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  function automatic int wrap_c(input int v);
    logic signed [CW-1:0] t;
    t = CW'(v);
    return int'(t);
  endfunction

  function automatic int sat_c(input int v);
    if (v > MAXI) return MAXI;
    if (v < MINI) return MINI;
    return v;
  endfunction

  function automatic logic [CW-1:0] model_x(input int ox, input int k);
    int raw;
    raw = wrap_c(ox + (k % NC) * BW);
`ifdef COORD_OFFSET_EN
    return CW'(sat_c(raw + cur_off_x));
`else
    return CW'(raw);
`endif
  endfunction

  function automatic logic [CW-1:0] model_y(input int oy, input int k);
    int raw;
    raw = wrap_c(oy + (k / NC) * BH);
`ifdef COORD_OFFSET_EN
    return CW'(sat_c(raw + cur_off_y));
`else
    return CW'(raw);
`endif
  endfunction

  function automatic int rand_coord();
    return int'($urandom_range(0, (1 << CW) - 1)) + MINI;
  endfunction

  task automatic check_idle_outputs(input string tag);
    checks += 6;
    if (bus.COORD_X !== '0) begin failures++; $display("[TB] FAIL %s COORD_X got %0d want 0", tag, bus.COORD_X); end
    if (bus.COORD_Y !== '0) begin failures++; $display("[TB] FAIL %s COORD_Y got %0d want 0", tag, bus.COORD_Y); end
    if (bus.VALID !== 1'b0) begin failures++; $display("[TB] FAIL %s VALID got %b want 0", tag, bus.VALID); end
    if (bus.LAST  !== 1'b0) begin failures++; $display("[TB] FAIL %s LAST got %b want 0", tag, bus.LAST); end
    if (bus.BUSY  !== 1'b0) begin failures++; $display("[TB] FAIL %s BUSY got %b want 0", tag, bus.BUSY); end
    if (bus.DONE  !== 1'b0) begin failures++; $display("[TB] FAIL %s DONE got %b want 0", tag, bus.DONE); end
  endtask

  // One complete scan from IDLE: START, walk all blocks with READY asserted
  // ready_pct percent of cycles, then check the DONE cycle and return to IDLE.
  task automatic run_scan(input int ox, input int oy, input int ready_pct, input bit poke_start);
    int k = 0;
    int edges = 0;
    int budget = 0;
    logic [CW-1:0] ex, ey;
    logic exp_last;
    bit rdy;
    bus.ORIGIN_X = CW'(ox);
    bus.ORIGIN_Y = CW'(oy);
    bus.READY    = 1'b0;
    bus.START    = 1'b1;
    tick;
    edges = 1;
    bus.START = 1'b0;
    while (k < NBLK && budget < 400) begin
      ex = model_x(ox, k);
      ey = model_y(oy, k);
      exp_last = (k == NBLK - 1);
      checks += 5;
      if (bus.VALID !== 1'b1) begin failures++; $display("[TB] FAIL scan_valid k=%0d got %b want 1", k, bus.VALID); end
      if (bus.BUSY  !== 1'b1) begin failures++; $display("[TB] FAIL scan_busy k=%0d got %b want 1", k, bus.BUSY); end
      if (bus.COORD_X !== ex) begin failures++; $display("[TB] FAIL scan_x k=%0d got %0d want %0d", k, bus.COORD_X, $signed(ex)); end
      if (bus.COORD_Y !== ey) begin failures++; $display("[TB] FAIL scan_y k=%0d got %0d want %0d", k, bus.COORD_Y, $signed(ey)); end
      if (bus.LAST !== exp_last) begin failures++; $display("[TB] FAIL scan_last k=%0d got %b want %b", k, bus.LAST, exp_last); end
      rdy = ($urandom_range(0, 99) < ready_pct);
      bus.READY = rdy;
      if (poke_start) begin
        bus.START    = 1'($urandom_range(0, 1));
        bus.ORIGIN_X = CW'($urandom);
        bus.ORIGIN_Y = CW'($urandom);
      end
      tick;
      edges++;
      budget++;
      if (rdy) k++;
    end
    bus.READY = 1'b0;
    bus.START = 1'b0;
    checks++;
    if (k < NBLK) begin failures++; $display("[TB] FAIL scan_budget accepted %0d want %0d", k, NBLK); end
    checks += 4;
    if (bus.VALID !== 1'b0) begin failures++; $display("[TB] FAIL fin_valid got %b want 0", bus.VALID); end
    if (bus.DONE  !== 1'b1) begin failures++; $display("[TB] FAIL fin_done got %b want 1", bus.DONE); end
    if (bus.BUSY  !== 1'b0) begin failures++; $display("[TB] FAIL fin_busy got %b want 0", bus.BUSY); end
    if (bus.LAST  !== 1'b0) begin failures++; $display("[TB] FAIL fin_last got %b want 0", bus.LAST); end
    if (ready_pct >= 100) begin
      checks++;
      if (edges != NBLK + 1) begin failures++; $display("[TB] FAIL cycle_count got %0d want %0d", edges, NBLK + 1); end
    end
    if (poke_start) begin
      bus.START    = 1'b1;
      bus.ORIGIN_X = CW'($urandom);
      bus.ORIGIN_Y = CW'($urandom);
    end
    tick;
    bus.START = 1'b0;
    checks += 2;
    if (bus.DONE  !== 1'b0) begin failures++; $display("[TB] FAIL done_pulse got %b want 0", bus.DONE); end
    if (bus.VALID !== 1'b0) begin failures++; $display("[TB] FAIL idle_valid got %b want 0", bus.VALID); end
    if (poke_start) begin
      tick;
      checks++;
      if (bus.VALID !== 1'b0) begin failures++; $display("[TB] FAIL fin_start_ignored VALID got %b want 0", bus.VALID); end
    end
  endtask

  task automatic test_reset;
    RST_SYNC     = 1'b1;
    bus.START    = 1'b1;
    bus.READY    = 1'b1;
    bus.ORIGIN_X = CW'(17);
    bus.ORIGIN_Y = CW'(33);
`ifdef COORD_OFFSET_EN
    bus.OFFSET_X = '0;
    bus.OFFSET_Y = '0;
`endif
    tick;
    tick;
    check_idle_outputs("reset");
    RST_SYNC  = 1'b0;
    bus.START = 1'b0;
    bus.READY = 1'b0;
    tick;
    check_idle_outputs("post_reset_idle");
  endtask

  task automatic test_basic;
    $display("[TB] basic scans, READY held high");
    run_scan(-4, -4, 100, 1'b0);
    for (int i = 0; i < 3; i++) run_scan(rand_coord(), rand_coord(), 100, 1'b0);
  endtask

  task automatic test_stall;
    $display("[TB] scans with random READY stalls");
    for (int i = 0; i < 4; i++) run_scan(rand_coord(), rand_coord(), 40, 1'b0);
  endtask

  task automatic test_wrap;
    $display("[TB] coordinate wrap");
    run_scan(120, 124, 100, 1'b0);
    run_scan(-128, 127, 60, 1'b0);
  endtask

  task automatic test_ignored_start;
    $display("[TB] START pokes during RUN and FIN");
    for (int i = 0; i < 3; i++) run_scan(rand_coord(), rand_coord(), 70, 1'b1);
  endtask

  task automatic test_reset_mid_run;
    $display("[TB] reset during a scan");
    bus.ORIGIN_X = CW'(10);
    bus.ORIGIN_Y = CW'(20);
    bus.START    = 1'b1;
    bus.READY    = 1'b0;
    tick;
    bus.START = 1'b0;
    bus.READY = 1'b1;
    tick;
    checks++;
    if (bus.COORD_X !== model_x(10, 1)) begin failures++; $display("[TB] FAIL midrun_second_x got %0d want %0d", bus.COORD_X, $signed(model_x(10, 1))); end
    RST_SYNC  = 1'b1;
    bus.START = 1'b1;
    tick;
    check_idle_outputs("midrun_reset");
    RST_SYNC  = 1'b0;
    bus.START = 1'b0;
    bus.READY = 1'b0;
    tick;
    check_idle_outputs("midrun_after_release");
    run_scan(10, 20, 100, 1'b0);
  endtask

`ifdef COORD_OFFSET_EN
  task automatic set_offset(input int ox, input int oy);
    cur_off_x    = ox;
    cur_off_y    = oy;
    bus.OFFSET_X = CW'(ox);
    bus.OFFSET_Y = CW'(oy);
  endtask

  task automatic test_offset;
    $display("[TB] saturating offset");
    set_offset(10, 0);
    run_scan(120, 0, 100, 1'b0);
    set_offset(-10, -10);
    run_scan(-125, -125, 100, 1'b0);
    for (int i = 0; i < 3; i++) begin
      set_offset(rand_coord(), rand_coord());
      run_scan(rand_coord(), rand_coord(), 60, 1'b0);
    end
    set_offset(0, 0);
  endtask
`endif

  initial begin
    $display("[TB] start");
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_ignored_start();
    test_reset_mid_run();
`ifdef COORD_OFFSET_EN
    test_offset();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/block_coord_scan.md
# block_coord_scan

Parametrised upper-left coordinate generator for the interpolation datapath. It replaces per-block software loading of single X/Y coordinate registers. After one START it walks a rectangular region of pixel blocks in raster order and presents each block's signed (X, Y) origin on a VALID/READY handshake. It sits between the block controller and the reference-pixel fetch/interpolation stages.

## Interface
- COORD_W, 8: signed coordinate width (two's complement)
- BLK_W, 8: horizontal step per block, pixels
- BLK_H, 8: vertical step per block, pixels
- NUM_COLS, 4: blocks per row (≥1)
- NUM_ROWS, 4: block rows per region (≥1)
- CLK  in  1  clock, rising edge
- RST_SYNC  in  1  reset, synchronous, active-high
- START  in  1  begin scan; sampled only in IDLE
- ORIGIN_X  in  COORD_W  signed region origin X, captured with START
- ORIGIN_Y  in  COORD_W  signed region origin Y, captured with START
- READY  in  1  consumer accepts current coordinate
- COORD_X  out  COORD_W  signed upper-left X of current block
- COORD_Y  out  COORD_W  signed upper-left Y of current block
- VALID  out  1  COORD_X/Y valid
- LAST  out  1  current coordinate is final block of region
- BUSY  out  1  scan in progress (state RUN)
- DONE  out  1  one-cycle pulse after final block accepted
- OFFSET_X, OFFSET_Y  in  COORD_W  signed offset (only with COORD_OFFSET_EN)

## Operation
- States: IDLE, RUN, FIN. Reset → IDLE.
- IDLE: START=1 → capture origin, col=row=0, → RUN.
- RUN: VALID=1. Transfer = VALID & READY.
  - Transfer, col<NUM_COLS-1: col+1, COORD_X += BLK_W.
  - Transfer, col=NUM_COLS-1, row<NUM_ROWS-1: col=0, row+1, COORD_X=origin X, COORD_Y += BLK_H.
  - Transfer with LAST=1 → FIN.
  - No transfer: all outputs held stable.
- FIN: DONE=1 for exactly one cycle → IDLE.
- LAST = (col=NUM_COLS-1) & (row=NUM_ROWS-1) & VALID.
- START is ignored in RUN and FIN. No restart without completing or resetting.
- Arithmetic: COORD_W-bit two's complement. Overflow wraps modulo 2^COORD_W, for example 120+8 = -128 at COORD_W=8.
- Counters: col is $clog2(NUM_COLS) bits, minimum 1; row likewise.
- Reset values: COORD_X=0, COORD_Y=0, VALID=0, LAST=0, BUSY=0, DONE=0, col=row=0, state IDLE.
- RST_SYNC has priority over every input. If asserted mid-RUN, the next edge returns all reset values and the scan is abandoned.

## Timing
- All outputs registered.
- START at edge t → VALID=1 with origin coordinates after edge t.
- Throughput: one coordinate per cycle while READY=1.
- Coordinate k (0-based) updates on the edge following its acceptance.
- The cycle after final acceptance has VALID=0 and DONE=1. START is accepted on the cycle after that, in IDLE.
- Total cycles START→DONE with READY held high: NUM_COLS·NUM_ROWS + 1.

## Configuration
- COORD_OFFSET_EN defined:
  - OFFSET_X/OFFSET_Y ports exist, carrying the motion-vector displacement.
  - COORD_X/Y = scan coordinate + offset, saturated to [-2^(COORD_W-1), 2^(COORD_W-1)-1].
  - The sum is registered, so latency is unchanged; the offset is sampled each cycle a new coordinate is loaded.
- COORD_OFFSET_EN undefined: ports absent, no adder, outputs are the raw scan coordinates with wrap.

## Structure
- Shared package coord_pkg:
  - state encoding localparams (IDLE=2'd0, RUN=2'd1, FIN=2'd2)
  - default COORD_W
  - signed saturation min/max constants
- Sub-module coord_sat_add (signed add with saturation, COORD_W parameter), instantiated twice only under COORD_OFFSET_EN.

## Test plan
- BLK 4×4, NUM_COLS=2, NUM_ROWS=2, origin (-4,-4), READY=1 → (-4,-4),(0,-4),(-4,0),(0,0); LAST on the 4th; DONE the next cycle; total 5 cycles.
- Same config, READY low for 3 cycles on the 2nd coordinate → (0,-4) held stable with VALID=1 for those 3 cycles, then sequence resumes.
- Origin X=120, BLK_W=8, NUM_COLS=2, no macro → X sequence 120, -128.
- COORD_OFFSET_EN, origin (120,0), OFFSET_X=10 → COORD_X=127 (saturated); OFFSET_X=-10 on origin -125 → -128.
- RST_SYNC asserted during the 2nd coordinate → next cycle all outputs 0, state IDLE; a fresh START restarts at origin.
- START pulsed during RUN and during FIN → ignored; sequence and DONE timing unchanged.
